// File: rtl/seq_mul_ctrl.sv
// Sequential unsigned W x W shift-add multiplier: one shared W-bit adder, W RUN cycles per product.
// The controller accepts in IDLE, runs W add/shift steps, then pulses DONE for one cycle.
module seq_mul_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic           BUSY,
    output logic           DONE,
    output logic           ADD_EN,
    output logic           SHIFT_EN,
    output logic [2*W-1:0] P
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    mq_q, mq_d;
    logic            c_q, c_d;
    logic [2*W-1:0]  p_q, p_d;

    logic [W:0]      addend;
    logic [W:0]      sum;

    // {C,ACC} is the (W+1)-bit partial product; C is always 0 after a shift.
    assign addend = mq_q[0] ? {1'b0, mcand_q} : '0;
    assign sum    = {c_q, acc_q} + addend;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            c_q     <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            c_q     <= c_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        c_d      = c_q;
        p_d      = p_q;
        DONE     = 1'b0;
        ADD_EN   = 1'b0;
        SHIFT_EN = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    mcand_d = A;
                    mq_d    = B;
                    acc_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                ADD_EN   = mq_q[0];
                SHIFT_EN = 1'b1;
                {c_d, acc_d, mq_d} = {1'b0, sum, mq_q[W-1:1]};
                if (cnt_q == CntLast) begin
                    // Counter holds at W-1; it is cleared again only on the next accept.
                    p_d     = {acc_d, mq_d};
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                DONE    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign BUSY = (state_q != StIdle);
    assign P    = p_q;

endmodule
